usb_rx_phy_decoder: RTL and testbench

Front end of the USB full-speed receive path, directly upstream of the RX packet controller and data buffer. It synchronises raw dp_in/dm_in, recovers 12 Mbps bit timing from the 100 MHz clk, and performs NRZI decoding, bit unstuffing, SYNC detection, byte assembly and EOP detection. It emits byte-valid pulses plus start/end/error strobes that the RX control FSM consumes.

---
 rtl/usb_rx_pkg.sv | 45 ++++
 rtl/usb_rx_bit_timer.sv | 95 +++++++++
 rtl/usb_rx_phy_decoder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_usb_rx_phy_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_pkg
// Description : Shared types and constants for the USB full-speed receive
//               front end: line-state encoding, receive FSM state codes,
//               SYNC / PID byte values and the D+/D- line-state decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_rx_pkg;

   // Differential line state as seen after synchronisation.
   typedef enum logic [1:0] {
      LS_J   = 2'd0,
      LS_K   = 2'd1,
      LS_SE0 = 2'd2,
      LS_SE1 = 2'd3
   } line_state_t;

   // Receive FSM state codes.
   typedef logic [2:0] rx_state_t;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SYNC     = 3'd1;
   localparam logic [2:0] ST_DATA     = 3'd2;
   localparam logic [2:0] ST_EOP      = 3'd3;
   localparam logic [2:0] ST_ERR_WAIT = 3'd4;

   // Decoded SYNC pattern (LSB first on the wire) and common PIDs.
   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam logic [7:0] PID_DATA0    = 8'hC3;
   localparam logic [7:0] PID_ACK      = 8'hD2;

   // Full-speed polarity: J = D+ high, K = D- high.
   function automatic line_state_t decode_line(input logic dp, input logic dm);
      line_state_t ls;
      case ({dp, dm})
         2'b10:   ls = LS_J;
         2'b01:   ls = LS_K;
         2'b00:   ls = LS_SE0;
         default: ls = LS_SE1;
      endcase
      return ls;
   endfunction

endpackage : usb_rx_pkg
`default_nettype wire

// File: rtl/usb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_bit_timer
// Description : Synchronises raw D+/D-, decodes the line state and recovers
//               bit timing. A cycle counter restarts on every line-state
//               change and otherwise wraps after BIT_PERIOD_BASE cycles
//               (one extra cycle on every LONG_BIT_EVERY-th bit), giving an
//               average of 8.33 clk per bit at 100 MHz.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               dp_i, dm_i    - raw asynchronous D+ / D-
//               line_o        - synchronised line state
//               sample_stb_o  - one-cycle strobe at the mid-bit sample point
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_bit_timer
   import usb_rx_pkg::*;
#(
   parameter int BIT_PERIOD_BASE = 8,
   parameter int LONG_BIT_EVERY  = 3,
   parameter int SAMPLE_POINT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dp_i,
   input  logic        dm_i,
   output line_state_t line_o,
   output logic        sample_stb_o
);

   localparam int CNT_W = $clog2(BIT_PERIOD_BASE + 2);
   localparam int IDX_W = (LONG_BIT_EVERY > 1) ? $clog2(LONG_BIT_EVERY) : 1;
   localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(BIT_PERIOD_BASE - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(BIT_PERIOD_BASE);
   localparam logic [CNT_W-1:0] SAMPLE_AT  = CNT_W'(SAMPLE_POINT);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LONG_BIT_EVERY - 1);

   logic [1:0]       dp_sync_q;
   logic [1:0]       dm_sync_q;
   line_state_t      w_line;
   line_state_t      line_prev_q;
   logic             w_change;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] w_last;

   // Two-flop synchronisers; reset to the idle J state so leaving reset
   // does not look like a line transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_sync_q <= 2'b11;
         dm_sync_q <= 2'b00;
      end else begin
         dp_sync_q <= {dp_sync_q[0], dp_i};
         dm_sync_q <= {dm_sync_q[0], dm_i};
      end
   end

   assign w_line   = decode_line(dp_sync_q[1], dm_sync_q[1]);
   assign w_change = (w_line != line_prev_q);
   assign w_last   = (idx_q == IDX_LAST) ? LONG_LAST : SHORT_LAST;

   // Any transition realigns both the cycle counter and the long-bit phase.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (w_change) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (cnt_q >= w_last) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_prev_q <= LS_J;
         cnt_q       <= '0;
         idx_q       <= '0;
      end else begin
         line_prev_q <= w_line;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
      end
   end

   // A transition landing exactly on the sample point would otherwise be
   // sampled twice (once now, once after the counter restarts).
   assign sample_stb_o = (cnt_q == SAMPLE_AT) && !w_change;
   assign line_o       = w_line;

endmodule : usb_rx_bit_timer
`default_nettype wire

// File: rtl/usb_rx_phy_decoder.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_phy_decoder
// Description : USB full-speed receive front end. NRZI decode, bit
//               unstuffing, SYNC detection, byte assembly and EOP detection
//               on top of usb_rx_bit_timer.
// Ports       : clk, rst        - 100 MHz clock, asynchronous active-high reset
//               dp_in, dm_in    - raw asynchronous D+ / D-
//               rx_active       - high from SYNC accepted until EOP / error
//               rx_start        - pulse when SYNC matched
//               rx_byte         - last assembled byte (LSB first on wire)
//               rx_byte_valid   - pulse, rx_byte holds a new byte
//               rx_eop          - pulse on a valid EOP
//               rx_err          - pulse on any receive error
//               err_count       - saturating rx_err count (USB_RX_ERR_CNT_EN)
// Options     : define USB_RX_ERR_CNT_EN to add the err_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_phy_decoder
   import usb_rx_pkg::*;
#(
   parameter int         BIT_PERIOD_BASE = 8,
   parameter int         LONG_BIT_EVERY  = 3,
   parameter int         SAMPLE_POINT    = 4,
   parameter logic [7:0] SYNC_BYTE       = SYNC_PATTERN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dp_in,
   input  logic       dm_in,
   output logic       rx_active,
   output logic       rx_start,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic       rx_eop,
`ifdef USB_RX_ERR_CNT_EN
   output logic [7:0] err_count,
`endif
   output logic       rx_err
);

   line_state_t w_line;
   logic        w_stb;

   usb_rx_bit_timer #(
      .BIT_PERIOD_BASE (BIT_PERIOD_BASE),
      .LONG_BIT_EVERY  (LONG_BIT_EVERY),
      .SAMPLE_POINT    (SAMPLE_POINT)
   ) u_bit_timer (
      .clk          (clk),
      .rst          (rst),
      .dp_i         (dp_in),
      .dm_i         (dm_in),
      .line_o       (w_line),
      .sample_stb_o (w_stb)
   );

   rx_state_t   state_q, state_d;
   line_state_t prev_jk_q, prev_jk_d;
   logic [2:0]  ones_q, ones_d;
   logic [7:0]  sr_q, sr_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [1:0]  se0cnt_q, se0cnt_d;
   logic        seen_se0_q, seen_se0_d;
   logic [2:0]  jcnt_q, jcnt_d;
   logic [7:0]  byte_q, byte_d;
   logic        active_q, active_d;
   logic        start_q, start_d;
   logic        valid_q, valid_d;
   logic        eop_q, eop_d;
   logic        err_q, err_d;
   logic        w_go_err;

   logic        w_is_jk;
   logic        w_bit;
   logic [7:0]  w_sr_next;

   assign w_is_jk   = (w_line == LS_J) || (w_line == LS_K);
   // NRZI: no transition since the previous J/K sample is a 1.
   assign w_bit     = (w_line == prev_jk_q);
   assign w_sr_next = {w_bit, sr_q[7:1]};

   always_comb begin
      state_d    = state_q;
      prev_jk_d  = prev_jk_q;
      ones_d     = ones_q;
      sr_d       = sr_q;
      bitcnt_d   = bitcnt_q;
      se0cnt_d   = se0cnt_q;
      seen_se0_d = seen_se0_q;
      jcnt_d     = jcnt_q;
      byte_d     = byte_q;
      active_d   = active_q;
      start_d    = 1'b0;
      valid_d    = 1'b0;
      eop_d      = 1'b0;
      err_d      = 1'b0;
      w_go_err   = 1'b0;

      if (w_stb) begin
         if (w_is_jk) begin
            prev_jk_d = w_line;
         end

         case (state_q)
            ST_IDLE: begin
               ones_d = '0;
               // The first K is already bit 0 of the SYNC pattern.
               if (w_line == LS_K) begin
                  sr_d     = w_sr_next;
                  bitcnt_d = 3'd1;
                  ones_d   = {2'b00, w_bit};
                  state_d  = ST_SYNC;
               end
            end

            ST_SYNC, ST_DATA: begin
               if ((w_line == LS_SE0) && (state_q == ST_DATA)) begin
                  state_d  = ST_EOP;
                  se0cnt_d = 2'd1;
               end else if (!w_is_jk) begin
                  w_go_err = 1'b1;
               end else if (ones_q == 3'd6) begin
                  // Stuffed bit: must be 0 and never enters the shift register.
                  ones_d = '0;
                  if (w_bit) begin
                     w_go_err = 1'b1;
                  end
               end else begin
                  sr_d     = w_sr_next;
                  bitcnt_d = bitcnt_q + 3'd1;
                  ones_d   = w_bit ? (ones_q + 3'd1) : 3'd0;
                  if (bitcnt_q == 3'd7) begin
                     if (state_q == ST_SYNC) begin
                        if (w_sr_next == SYNC_BYTE) begin
                           start_d  = 1'b1;
                           active_d = 1'b1;
                           state_d  = ST_DATA;
                        end else begin
                           w_go_err = 1'b1;
                        end
                     end else begin
                        byte_d  = w_sr_next;
                        valid_d = 1'b1;
                     end
                  end
               end
            end

            ST_EOP: begin
               case (w_line)
                  LS_SE0: begin
                     if (se0cnt_q != 2'd2) begin
                        se0cnt_d = se0cnt_q + 2'd1;
                     end
                  end
                  LS_J: begin
                     if (se0cnt_q == 2'd2) begin
                        eop_d    = 1'b1;
                        // A partial byte is flagged alongside the EOP.
                        err_d    = (bitcnt_q != 3'd0);
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                     end else begin
                        w_go_err = 1'b1;
                     end
                  end
                  default: w_go_err = 1'b1;
               endcase
            end

            ST_ERR_WAIT: begin
               case (w_line)
                  LS_SE0: begin
                     seen_se0_d = 1'b1;
                     jcnt_d     = '0;
                  end
                  LS_J: begin
                     if (seen_se0_q || (jcnt_q == 3'd7)) begin
                        state_d = ST_IDLE;
                     end else begin
                        jcnt_d = jcnt_q + 3'd1;
                     end
                  end
                  default: begin
                     seen_se0_d = 1'b0;
                     jcnt_d     = '0;
                  end
               endcase
            end

            default: state_d = ST_IDLE;
         endcase
      end

      if (w_go_err) begin
         err_d      = 1'b1;
         active_d   = 1'b0;
         state_d    = ST_ERR_WAIT;
         seen_se0_d = 1'b0;
         jcnt_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prev_jk_q  <= LS_J;
         ones_q     <= '0;
         sr_q       <= '0;
         bitcnt_q   <= '0;
         se0cnt_q   <= '0;
         seen_se0_q <= 1'b0;
         jcnt_q     <= '0;
         byte_q     <= 8'h00;
         active_q   <= 1'b0;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
         eop_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_jk_q  <= prev_jk_d;
         ones_q     <= ones_d;
         sr_q       <= sr_d;
         bitcnt_q   <= bitcnt_d;
         se0cnt_q   <= se0cnt_d;
         seen_se0_q <= seen_se0_d;
         jcnt_q     <= jcnt_d;
         byte_q     <= byte_d;
         active_q   <= active_d;
         start_q    <= start_d;
         valid_q    <= valid_d;
         eop_q      <= eop_d;
         err_q      <= err_d;
      end
   end

   assign rx_active     = active_q;
   assign rx_start      = start_q;
   assign rx_byte       = byte_q;
   assign rx_byte_valid = valid_q;
   assign rx_eop        = eop_q;
   assign rx_err        = err_q;

`ifdef USB_RX_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'h00;
      end else if (err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'h01;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule : usb_rx_phy_decoder
`default_nettype wire

// File: tb/tb_usb_rx_phy_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_phy_decoder
// Description : Self-checking bench for usb_rx_phy_decoder. Drives line
//               states with an 8,8,9-cycle bit cadence, uses a small NRZI /
//               bit-stuffing encoder for table-driven packets and raw line
//               state sequences for the hand-written corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_phy_decoder;
   import usb_rx_pkg::*;

   logic       clk;
   logic       rst;
   logic       dp_in;
   logic       dm_in;
   logic       rx_active;
   logic       rx_start;
   logic [7:0] rx_byte;
   logic       rx_byte_valid;
   logic       rx_eop;
   logic       rx_err;
`ifdef USB_RX_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   usb_rx_phy_decoder dut (
      .clk           (clk),
      .rst           (rst),
      .dp_in         (dp_in),
      .dm_in         (dm_in),
      .rx_active     (rx_active),
      .rx_start      (rx_start),
      .rx_byte       (rx_byte),
      .rx_byte_valid (rx_byte_valid),
      .rx_eop        (rx_eop),
`ifdef USB_RX_ERR_CNT_EN
      .err_count     (err_count),
`endif
      .rx_err        (rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checks
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // --------------------------------------------------------------- monitor
   logic [7:0] got_q[$];
   int n_start = 0, n_eop = 0, n_err = 0, n_eop_err = 0;
   int n_act_start = 0, n_fall_eop = 0, n_fall_other = 0;
   logic act_prev = 1'b0;

   always @(negedge clk) begin
      if (rx_start) begin
         n_start++;
         if (rx_active) n_act_start++;
      end
      if (rx_byte_valid) got_q.push_back(rx_byte);
      if (rx_eop) n_eop++;
      if (rx_err) n_err++;
      if (rx_eop && rx_err) n_eop_err++;
      if (act_prev && !rx_active) begin
         if (rx_eop) n_fall_eop++;
         else        n_fall_other++;
      end
      act_prev = rx_active;
   end

   int b_start, b_bytes, b_eop, b_err, b_eop_err, b_act_start, b_fall_eop, b_fall_other;

   task automatic snap();
      b_start      = n_start;
      b_bytes      = got_q.size();
      b_eop        = n_eop;
      b_err        = n_err;
      b_eop_err    = n_eop_err;
      b_act_start  = n_act_start;
      b_fall_eop   = n_fall_eop;
      b_fall_other = n_fall_other;
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got_q.size()) return {24'h0, got_q[i]};
      return 32'hFFFF_FFFF;
   endfunction

   task automatic check_pkt(input string tag, input int e_start, input int e_bytes,
                            input int e_eop, input int e_err, input int e_eop_err);
      check($sformatf("%s.start", tag),   n_start - b_start,         e_start);
      check($sformatf("%s.nbytes", tag),  got_q.size() - b_bytes,    e_bytes);
      check($sformatf("%s.eop", tag),     n_eop - b_eop,             e_eop);
      check($sformatf("%s.err", tag),     n_err - b_err,             e_err);
      check($sformatf("%s.eop_err", tag), n_eop_err - b_eop_err,     e_eop_err);
   endtask

   task automatic check_active_span(input string tag);
      check($sformatf("%s.active_at_start", tag), n_act_start - b_act_start, 1);
      check($sformatf("%s.active_fall_eop", tag), n_fall_eop - b_fall_eop, 1);
      check($sformatf("%s.active_fall_early", tag), n_fall_other - b_fall_other, 0);
   endtask

   // ----------------------------------------------------------- line driver
   line_state_t tx_prev;
   int          tx_ones;
   int          tx_phase;

   task automatic put_ls(input line_state_t ls);
      case (ls)
         LS_J:    {dp_in, dm_in} = 2'b10;
         LS_K:    {dp_in, dm_in} = 2'b01;
         LS_SE0:  {dp_in, dm_in} = 2'b00;
         default: {dp_in, dm_in} = 2'b11;
      endcase
      repeat ((tx_phase == 2) ? 9 : 8) @(posedge clk);
      tx_phase = (tx_phase == 2) ? 0 : tx_phase + 1;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) put_ls(LS_J);
      tx_prev = LS_J;
      tx_ones = 0;
   endtask

   task automatic send_bit(input logic b);
      if (!b) tx_prev = (tx_prev == LS_J) ? LS_K : LS_J;
      put_ls(tx_prev);
      tx_ones = b ? tx_ones + 1 : 0;
      if (tx_ones == 6) begin
         tx_prev = (tx_prev == LS_J) ? LS_K : LS_J;
         put_ls(tx_prev);
         tx_ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic send_sync();
      tx_prev = LS_J;
      tx_ones = 0;
      send_byte(8'h80);
   endtask

   task automatic send_eop();
      put_ls(LS_SE0);
      put_ls(LS_SE0);
      idle(5);
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic [7:0] pid;
      logic [7:0] payload;
      int         n_payload;
      logic [7:0] exp_b0;
      logic [7:0] exp_b1;
   } pkt_vec_t;

   localparam int NVEC = 7;
   pkt_vec_t vecs [NVEC];

   line_state_t raw_good [19];
   line_state_t raw_bad_sync [8];

   initial begin
      vecs[0] = '{pid: PID_DATA0, payload: 8'hA8, n_payload: 1, exp_b0: 8'hC3, exp_b1: 8'hA8};
      vecs[1] = '{pid: PID_ACK,   payload: 8'h00, n_payload: 0, exp_b0: 8'hD2, exp_b1: 8'h00};
      vecs[2] = '{pid: PID_DATA0, payload: 8'hFF, n_payload: 1, exp_b0: 8'hC3, exp_b1: 8'hFF};
      vecs[3] = '{pid: PID_DATA0, payload: 8'h00, n_payload: 1, exp_b0: 8'hC3, exp_b1: 8'h00};
      vecs[4] = '{pid: PID_DATA0, payload: 8'h7E, n_payload: 1, exp_b0: 8'hC3, exp_b1: 8'h7E};
      vecs[5] = '{pid: 8'hFF,     payload: 8'hFF, n_payload: 1, exp_b0: 8'hFF, exp_b1: 8'hFF};
      vecs[6] = '{pid: PID_DATA0, payload: 8'h3F, n_payload: 1, exp_b0: 8'hC3, exp_b1: 8'h3F};

      raw_good = '{LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K,
                   LS_K, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K, LS_K,
                   LS_SE0, LS_SE0, LS_J};
      raw_bad_sync = '{LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_J};

      rst = 1'b1; dp_in = 1'b1; dm_in = 1'b0;
      tx_prev = LS_J; tx_ones = 0; tx_phase = 0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.rx_active", rx_active, 0);
      check("reset.rx_start", rx_start, 0);
      check("reset.rx_byte", rx_byte, 8'h00);
      check("reset.rx_byte_valid", rx_byte_valid, 0);
      check("reset.rx_eop", rx_eop, 0);
      check("reset.rx_err", rx_err, 0);
`ifdef USB_RX_ERR_CNT_EN
      check("reset.err_count", err_count, 0);
`endif
      @(posedge clk); #1 rst = 1'b0;
      idle(10);

      // Hand-encoded SYNC + DATA0 + EOP.
      snap();
      foreach (raw_good[i]) put_ls(raw_good[i]);
      idle(4);
      check_pkt("raw_data0", 1, 1, 1, 0, 0);
      check("raw_data0.byte", got_at(b_bytes), 8'hC3);
      check_active_span("raw_data0");
      check("raw_data0.active_after", rx_active, 0);

      // Table-driven packets through the NRZI / stuffing encoder.
      for (int v = 0; v < NVEC; v++) begin
         snap();
         send_sync();
         send_byte(vecs[v].pid);
         if (vecs[v].n_payload > 0) send_byte(vecs[v].payload);
         send_eop();
         check_pkt($sformatf("vec%0d", v), 1, 1 + vecs[v].n_payload, 1, 0, 0);
         check($sformatf("vec%0d.byte0", v), got_at(b_bytes), vecs[v].exp_b0);
         if (vecs[v].n_payload > 0)
            check($sformatf("vec%0d.byte1", v), got_at(b_bytes + 1), vecs[v].exp_b1);
         check_active_span($sformatf("vec%0d", v));
      end

      // Long packet: DATA0 + 64 x 8'hA8.
      snap();
      send_sync();
      send_byte(PID_DATA0);
      repeat (64) send_byte(8'hA8);
      send_eop();
      check_pkt("long", 1, 65, 1, 0, 0);
      check("long.pid", got_at(b_bytes), 8'hC3);
      for (int i = 1; i <= 64; i++)
         check($sformatf("long.byte%0d", i), got_at(b_bytes + i), 8'hA8);
      check_active_span("long");

      // Stuffing violation: seven identical states after SYNC.
      snap();
      send_sync();
      repeat (7) put_ls(LS_K);
      @(negedge clk);
      check_pkt("stuff_err", 1, 0, 0, 1, 0);
      check("stuff_err.rx_active", rx_active, 0);
      send_eop();
      snap();
      send_sync();
      send_byte(PID_DATA0);
      send_eop();
      check_pkt("after_stuff_err", 1, 1, 1, 0, 0);
      check("after_stuff_err.byte", got_at(b_bytes), 8'hC3);

      // Corrupted SYNC.
      snap();
      foreach (raw_bad_sync[i]) put_ls(raw_bad_sync[i]);
      idle(12);
      check_pkt("bad_sync", 0, 0, 0, 1, 0);
      check("bad_sync.rx_active", rx_active, 0);

      // EOP after 12 data bits: one byte, then EOP flagged with an error.
      snap();
      send_sync();
      send_byte(PID_DATA0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_eop();
      check_pkt("partial", 1, 1, 1, 1, 1);
      check("partial.byte", got_at(b_bytes), 8'hC3);

      // Reset in the middle of a byte.
      send_sync();
      send_byte(PID_DATA0);
      send_bit(1'b1); send_bit(1'b0);
      check("midrst.pre_active", rx_active, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("midrst.rx_active", rx_active, 0);
      check("midrst.rx_byte", rx_byte, 8'h00);
      check("midrst.strobes", {rx_start, rx_byte_valid, rx_eop, rx_err}, 4'b0000);
`ifdef USB_RX_ERR_CNT_EN
      check("midrst.err_count", err_count, 0);
`endif
      snap();
      {dp_in, dm_in} = 2'b10;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(16);
      check_pkt("midrst.after", 0, 0, 0, 0, 0);

`ifdef USB_RX_ERR_CNT_EN
      // 260 short error packets (K then SE1) saturate the counter.
      snap();
      repeat (260) begin
         put_ls(LS_K);
         put_ls(LS_SE1);
         put_ls(LS_SE0);
         idle(2);
      end
      check("errcnt.pulses", n_err - b_err, 260);
      check("errcnt.saturated", err_count, 8'hFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_usb_rx_phy_decoder
`default_nettype wire
